// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: register map,
// CTRL field positions and the active-low glyph set {A..G,DP}.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_CTRL = 2'd1,
    REG_DIV  = 2'd2,
    REG_DUTY = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_LZS_BIT      = 1;
  localparam int CTRL_DIG_MASK_LSB = 8;
  localparam int CTRL_DP_MASK_LSB  = 16;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  // Suppressed leading digit that still carries its decimal point.
  localparam logic [7:0] SEG_DP_ONLY = 8'hFE;

  localparam logic [7:0] GLYPH_0 = 8'h03;
  localparam logic [7:0] GLYPH_1 = 8'h9F;
  localparam logic [7:0] GLYPH_2 = 8'h25;
  localparam logic [7:0] GLYPH_3 = 8'h0D;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h49;
  localparam logic [7:0] GLYPH_6 = 8'h41;
  localparam logic [7:0] GLYPH_7 = 8'h1F;
  localparam logic [7:0] GLYPH_8 = 8'h01;
  localparam logic [7:0] GLYPH_9 = 8'h09;
  localparam logic [7:0] GLYPH_A = 8'h11;
  localparam logic [7:0] GLYPH_B = 8'hC1;
  localparam logic [7:0] GLYPH_C = 8'h63;
  localparam logic [7:0] GLYPH_D = 8'h85;
  localparam logic [7:0] GLYPH_E = 8'h61;
  localparam logic [7:0] GLYPH_F = 8'h71;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment glyph; DP bit is always 1 (off) here.
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph
);

  always_comb begin
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// MMIO seven-segment scanner: DATA/CTRL/DIV/DUTY registers, digit scan with
// enable/DP masks, leading-zero suppression and in-slot PWM brightness.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 300000,
  parameter int CNT_W      = 32   // must not exceed the 32-bit bus
) (
  input  logic                  seg_clk,
  input  logic                  seg_rst,
  input  logic [31:0]           seg_addr,
  input  logic                  seg_we,
  input  logic [31:0]           seg_wdata,
  output logic [31:0]           seg_rdata,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  DN_A,
  output logic                  DN_B,
  output logic                  DN_C,
  output logic                  DN_D,
  output logic                  DN_E,
  output logic                  DN_F,
  output logic                  DN_G,
  output logic                  DN_DP
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DATA_W-1:0]     data_q;
  logic                  en_q;
  logic                  lzs_q;
  logic [NUM_DIGITS-1:0] dig_mask_q;
  logic [NUM_DIGITS-1:0] dp_mask_q;
  logic [CNT_W-1:0]      div_q;
  logic [CNT_W-1:0]      duty_q;
  logic [CNT_W-1:0]      slot_cnt_q;
  logic [IDX_W-1:0]      scan_idx_q;
  logic [7:0]            seg_q;

  reg_sel_e              reg_sel;
  logic                  en_next;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            cur_nibble;
  logic [7:0]            cur_glyph;
  logic                  slot_on;
  logic                  show_glyph;
  logic                  show_dp;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic [31:0]           rd_mux;
  logic                  unused_bits;

  assign reg_sel = reg_sel_e'(seg_addr[3:2]);
  // A write clearing en must beat a coincident slot boundary.
  assign en_next = (seg_we && reg_sel == REG_CTRL) ? seg_wdata[CTRL_EN_BIT] : en_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lzs
    if (i == 0) begin : g_first
      assign blank[i] = 1'b0;
    end else begin : g_rest
      assign blank[i] = lzs_q && (data_q[DATA_W-1:4*i] == '0);
    end
  end

  assign cur_nibble = data_q[{scan_idx_q, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  assign slot_on    = en_q && dig_mask_q[scan_idx_q] && (slot_cnt_q < duty_q);
  assign show_glyph = slot_on && !blank[scan_idx_q];
  assign show_dp    = slot_on && blank[scan_idx_q] && dp_mask_q[scan_idx_q];

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    dig_sel             = '1;
    dig_sel[scan_idx_q] = 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA: rd_mux[DATA_W-1:0] = data_q;
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]                         = en_q;
        rd_mux[CTRL_LZS_BIT]                        = lzs_q;
        rd_mux[CTRL_DIG_MASK_LSB +: NUM_DIGITS]     = dig_mask_q;
        rd_mux[CTRL_DP_MASK_LSB +: NUM_DIGITS]      = dp_mask_q;
      end
      REG_DIV:  rd_mux[CNT_W-1:0] = div_q;
      REG_DUTY: rd_mux[CNT_W-1:0] = duty_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      data_q     <= '0;
      en_q       <= 1'b1;
      lzs_q      <= 1'b0;
      dig_mask_q <= '1;
      dp_mask_q  <= '0;
      div_q      <= CNT_W'(SCAN_DIV);
      duty_q     <= '1;
    end else if (seg_we) begin
      case (reg_sel)
        REG_DATA: data_q <= seg_wdata[DATA_W-1:0];
        REG_CTRL: begin
          en_q       <= seg_wdata[CTRL_EN_BIT];
          lzs_q      <= seg_wdata[CTRL_LZS_BIT];
          dig_mask_q <= seg_wdata[CTRL_DIG_MASK_LSB +: NUM_DIGITS];
          dp_mask_q  <= seg_wdata[CTRL_DP_MASK_LSB +: NUM_DIGITS];
        end
        REG_DIV:  div_q  <= seg_wdata[CNT_W-1:0];
        REG_DUTY: duty_q <= seg_wdata[CNT_W-1:0];
      endcase
    end
  end

  always_ff @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      slot_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (!en_q || !en_next) begin
      slot_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (slot_cnt_q >= div_q) begin
      slot_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      slot_cnt_q <= slot_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      dig_en    <= '1;
      seg_q     <= SEG_BLANK;
      seg_rdata <= '0;
    end else begin
      dig_en    <= (show_glyph || show_dp) ? dig_sel : '1;
      seg_q     <= show_glyph ? {cur_glyph[7:1], ~dp_mask_q[scan_idx_q]} :
                   show_dp    ? SEG_DP_ONLY : SEG_BLANK;
      seg_rdata <= rd_mux;
    end
  end

  assign {DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP} = seg_q;

  assign unused_bits = ^{seg_addr[31:4], seg_addr[1:0], seg_wdata, cur_glyph[0]};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a register-level display model compared
// every cycle, plus directed scenarios with literal expected values.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 300000;
  localparam logic [7:0] GLYPH_TAB [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic        seg_clk = 1'b0;
  logic        seg_rst;
  logic [31:0] seg_addr;
  logic        seg_we;
  logic [31:0] seg_wdata;
  logic [31:0] seg_rdata;
  logic [7:0]  dig_en;
  logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;
  logic [7:0]  seg_vec;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS (8),
    .SCAN_DIV   (SCAN_DIV),
    .CNT_W      (32)
  ) dut (
    .seg_clk   (seg_clk),
    .seg_rst   (seg_rst),
    .seg_addr  (seg_addr),
    .seg_we    (seg_we),
    .seg_wdata (seg_wdata),
    .seg_rdata (seg_rdata),
    .dig_en    (dig_en),
    .DN_A      (DN_A),
    .DN_B      (DN_B),
    .DN_C      (DN_C),
    .DN_D      (DN_D),
    .DN_E      (DN_E),
    .DN_F      (DN_F),
    .DN_G      (DN_G),
    .DN_DP     (DN_DP)
  );

  assign seg_vec = {DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP};

  always #5 seg_clk = ~seg_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- display model: register view + slot position ----------------
  logic [31:0] m_data, m_div, m_duty, m_slot;
  logic        m_en, m_lzs;
  logic [7:0]  m_dmask, m_dpmask;
  int          m_idx;
  logic [7:0]  exp_dig, exp_seg;
  logic [31:0] exp_rd;

  function automatic logic [15:0] model_display();
    logic [7:0] g;
    logic       on, suppressed;
    int         i;
    i          = m_idx;
    on         = m_en && m_dmask[i] && (m_slot < m_duty);
    suppressed = m_lzs && (i > 0) && ((m_data >> (4 * i)) == 32'd0);
    if (!on) return 16'hFFFF;
    if (!suppressed) begin
      g = GLYPH_TAB[m_data[4*i +: 4]];
      return {~(8'd1 << i), g[7:1], ~m_dpmask[i]};
    end
    if (m_dpmask[i]) return {~(8'd1 << i), 8'hFE};
    return 16'hFFFF;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_data;
      2'd1:    return {8'h00, m_dpmask, m_dmask, 6'd0, m_lzs, m_en};
      2'd2:    return m_div;
      default: return m_duty;
    endcase
  endfunction

  always @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      m_data <= 0; m_en <= 1'b1; m_lzs <= 1'b0; m_dmask <= 8'hFF; m_dpmask <= 8'h00;
      m_div <= SCAN_DIV; m_duty <= 32'hFFFF_FFFF; m_slot <= 0; m_idx <= 0;
      {exp_dig, exp_seg} <= 16'hFFFF;
      exp_rd <= 0;
    end else begin
      {exp_dig, exp_seg} <= model_display();
      exp_rd <= model_read(seg_addr[3:2]);
      if (!m_en || (seg_we && seg_addr[3:2] == 2'd1 && !seg_wdata[0])) begin
        m_slot <= 0;
        m_idx  <= 0;
      end else if (m_slot >= m_div) begin
        m_slot <= 0;
        m_idx  <= (m_idx + 1) % 8;
      end else begin
        m_slot <= m_slot + 1;
      end
      if (seg_we) begin
        case (seg_addr[3:2])
          2'd0: m_data <= seg_wdata;
          2'd1: begin
            m_en <= seg_wdata[0]; m_lzs <= seg_wdata[1];
            m_dmask <= seg_wdata[15:8]; m_dpmask <= seg_wdata[23:16];
          end
          2'd2: m_div  <= seg_wdata;
          default: m_duty <= seg_wdata;
        endcase
      end
    end
  end

  always @(negedge seg_clk) begin
    if (!seg_rst && cmp_on) begin
      check("model dig_en", dig_en, exp_dig);
      check("model seg", seg_vec, exp_seg);
      check("model rdata", seg_rdata, exp_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge seg_clk);
    seg_addr = a; seg_wdata = d; seg_we = 1'b1;
    @(negedge seg_clk);
    seg_we = 1'b0;
  endtask

  task automatic wait_dig(input logic [7:0] target, input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge seg_clk);
      if (dig_en == target) found = 1'b1;
    end
  endtask

  task automatic observe(input int n, output logic [7:0] lit_set, output int lit_cnt);
    lit_set = 8'h00;
    lit_cnt = 0;
    repeat (n) begin
      @(negedge seg_clk);
      lit_set |= ~dig_en;
      if (dig_en != 8'hFF) lit_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         f;
    int         n, cnt;
    logic [7:0] set;

    seg_rst = 1'b1; seg_addr = 0; seg_we = 1'b0; seg_wdata = 0;
    #12;
    check("reset dig_en", dig_en, 8'hFF);
    check("reset seg", seg_vec, 8'hFF);
    check("reset rdata", seg_rdata, 32'h0);
    @(negedge seg_clk);
    seg_rst = 1'b0;
    cmp_on  = 1'b1;

    // 1: full scan, 4 clocks per slot, wrap 7 -> 0
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h7654_3210);
    wait_dig(8'hFB, 100, f);
    check("t1 digit2 found", f, 1);
    check("t1 digit2 seg", seg_vec, 8'h25);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge seg_clk);
      if (dig_en != 8'hFB) break;
      n++;
    end
    check("t1 slot length", n, 4);
    wait_dig(8'h7F, 100, f);
    check("t1 digit7 found", f, 1);
    repeat (4) @(negedge seg_clk);
    check("t1 wrap to digit0", dig_en, 8'hFE);

    // 2: leading-zero suppression
    wr(32'h4, 32'h0000_FF03);
    wr(32'h0, 32'h0000_0050);
    repeat (2) @(negedge seg_clk);
    observe(40, set, cnt);
    check("t2 lit set 0x50", set, 8'h03);
    wait_dig(8'hFD, 100, f);
    check("t2 digit1 found", f, 1);
    check("t2 digit1 seg", seg_vec, 8'h49);
    wait_dig(8'hFE, 100, f);
    check("t2 digit0 seg", seg_vec, 8'h03);
    wr(32'h0, 32'h0);
    repeat (2) @(negedge seg_clk);
    observe(40, set, cnt);
    check("t2 lit set zero", set, 8'h01);
    wait_dig(8'hFE, 100, f);
    check("t2 zero digit0 seg", seg_vec, 8'h03);

    // 3: PWM within a 10-clock slot
    wr(32'h4, 32'h0000_FF01);
    wr(32'h0, 32'h7654_3210);
    wr(32'h8, 32'd9);
    wr(32'hC, 32'd4);
    repeat (12) @(negedge seg_clk);
    observe(80, set, cnt);
    check("t3 duty4 lit clocks", cnt, 32);
    check("t3 duty4 lit set", set, 8'hFF);
    wr(32'hC, 32'd0);
    repeat (2) @(negedge seg_clk);
    observe(80, set, cnt);
    check("t3 duty0 lit clocks", cnt, 0);
    wr(32'hC, 32'd20);
    repeat (2) @(negedge seg_clk);
    observe(80, set, cnt);
    check("t3 duty20 lit clocks", cnt, 80);
    wr(32'h8, 32'd3);
    wr(32'hC, 32'hFFFF_FFFF);

    // 4: digit and DP masks, CTRL readback
    wr(32'h4, 32'h0001_0F01);
    repeat (2) @(negedge seg_clk);
    observe(40, set, cnt);
    check("t4 lit set", set, 8'h0F);
    wait_dig(8'hFE, 100, f);
    check("t4 digit0 dp seg", seg_vec, 8'h02);
    seg_addr = 32'h4;
    @(negedge seg_clk);
    check("t4 read CTRL", seg_rdata, 32'h0001_0F01);

    // 5: disable on the exact slot-boundary edge, then re-enable
    wr(32'h4, 32'h0000_FF01);
    f = 1'b0;
    for (int k = 0; k < 100 && !f; k++) begin
      @(negedge seg_clk);
      if (m_en && m_slot == m_div && m_idx == 3) f = 1'b1;
    end
    check("t5 boundary found", f, 1);
    seg_addr = 32'h4; seg_wdata = 32'h0000_FF00; seg_we = 1'b1;
    @(negedge seg_clk);
    seg_we = 1'b0;
    @(negedge seg_clk);
    check("t5 disabled dig_en", dig_en, 8'hFF);
    check("t5 disabled seg", seg_vec, 8'hFF);
    observe(8, set, cnt);
    check("t5 stays dark", set, 8'h00);
    wr(32'h4, 32'h0000_FF01);
    @(negedge seg_clk);
    check("t5 restart digit0", dig_en, 8'hFE);

    // 6: asynchronous reset mid-slot
    repeat (3) @(negedge seg_clk);
    @(posedge seg_clk);
    #2 seg_rst = 1'b1;
    #1;
    check("t6 async dig_en", dig_en, 8'hFF);
    check("t6 async seg", seg_vec, 8'hFF);
    check("t6 async rdata", seg_rdata, 32'h0);
    @(negedge seg_clk);
    seg_rst  = 1'b0;
    seg_addr = 32'h8;
    @(negedge seg_clk);
    check("t6 read DIV", seg_rdata, 32'd300000);
    check("t6 post-reset digit0", dig_en, 8'hFE);
    check("t6 post-reset seg", seg_vec, 8'h03);
    repeat (4) @(negedge seg_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
